// File: rtl/led_fade_driver.sv
// LED fade driver: ramps a PWM duty one LSB per STEP_DIV clocks toward the synchronized target.
// Optional LED_FADE_GAMMA_EN selects a quadratic duty-to-compare curve (default: linear).
module led_fade_driver #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 49000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_in,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int unsigned StepW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DutyFull = '1;

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StRise = 2'b01,
    StOn   = 2'b10,
    StFall = 2'b11
  } state_e;

  logic                sync1_q, sync2_q;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                busy_q, busy_d;
  logic                led_q, led_d;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] cmp;
  state_e              state;

  // duty_max is used unsynchronized; only the on/off level crosses domains
  assign target = sync2_q ? duty_max : '0;

  // State is a pure function of duty and target, re-derived every clock
  always_comb begin
    if (duty_q == target) begin
      state = (duty_q == '0) ? StOff : StOn;
    end else begin
      state = (duty_q < target) ? StRise : StFall;
    end
  end

  always_comb begin
    duty_d = duty_q;
    step_d = step_q;
    unique case (state)
      StOff, StOn: step_d = '0;
      StRise, StFall: begin
        // Step counter is deliberately not cleared on RISE<->FALL reversal
        if (step_q == StepLast) begin
          step_d = '0;
          duty_d = (state == StRise) ? duty_q + 1'b1 : duty_q - 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: step_d = '0;
    endcase
    busy_d = (duty_d != target);
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
  assign cmp     = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign cmp = duty_q;
`endif

  // Full-on is keyed on duty so the top code gives a constant-high pin
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    led_d     = (duty_q == DutyFull) || (pwm_cnt_q < cmp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      duty_q    <= '0;
      step_q    <= '0;
      pwm_cnt_q <= '0;
      busy_q    <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      sync1_q   <= led_in;
      sync2_q   <= sync1_q;
      duty_q    <= duty_d;
      step_q    <= step_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= busy_d;
      led_q     <= led_d;
    end
  end

  assign led_out = led_q;
  assign duty    = duty_q;
  assign busy    = busy_q;

endmodule
